psum_load_ctrl: RTL and testbench

//  Read-side counterpart of the psum store path. Fetches previously stored partial sums from the
//  GLB psum bank and streams them to the PE-array accumulation input with valid/ready flow control.

---
 rtl/psum_ctrl_pkg.sv | 25 ++
 rtl/psum_skid_fifo.sv | 55 +++++
 rtl/psum_load_ctrl.sv | 136 +++++++++++++
 tb/tb_psum_load_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/psum_ctrl_pkg.sv
// Shared definitions for the psum store/load controllers: word and address
// widths, FSM state encodings, and the address walk used by both sides.
package psum_ctrl_pkg;

  localparam int PSUM_ADDR_W = 16;
  localparam int PSUM_DATA_W = 16;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_LOAD         = 3'd1;
  localparam logic [2:0] ST_DRAIN        = 3'd2;
  localparam logic [2:0] ST_UPDATE_BASE  = 3'd3;
  localparam logic [2:0] ST_UPDATE_BATCH = 3'd4;
  localparam logic [2:0] ST_DONE         = 3'd5;

  // cnt_p*EF*EF + cnt_e*EF + iter at full 32-bit width; callers truncate.
  function automatic logic [31:0] psum_addr(input logic [2:0] cnt_p,
                                            input logic [6:0] cnt_e,
                                            input logic [6:0] iter,
                                            input logic [6:0] ef);
    logic [31:0] ef_w;
    ef_w = {25'd0, ef};
    return ({29'd0, cnt_p} * ef_w * ef_w) + ({25'd0, cnt_e} * ef_w) + {25'd0, iter};
  endfunction

endpackage

// File: rtl/psum_skid_fifo.sv
// Small synchronous show-ahead FIFO that buffers returning psum words
// ({last, data}) so GLB reads can run ahead of PE-array backpressure.
module psum_skid_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 17,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_load_ctrl.sv
// Psum reload controller: walks the GLB psum bank in store-side order,
// issues credit-limited reads (or injects zeros), buffers returns in a
// skid FIFO and streams them to the PE array with valid/ready.
module psum_load_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int ADDR_W     = PSUM_ADDR_W,
  parameter int DATA_W     = PSUM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_zero_init,
  input  logic [6:0]        i_layer_EF,
  input  logic [2:0]        i_layer_p,
  input  logic [2:0]        i_layer_n,
  output logic              o_psum_glb_re,
  output logic [ADDR_W-1:0] o_psum_glb_ra,
  input  logic [DATA_W-1:0] i_psum_glb_rd,
  output logic              o_psum_valid,
  output logic [DATA_W-1:0] o_psum_data,
  output logic              o_psum_last,
  input  logic              i_psum_ready,
  output logic              o_iter_done,
  output logic              o_load_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [2:0]        cnt_p;
  logic [6:0]        cnt_e;
  logic [6:0]        iter_cnt;
  logic [2:0]        batch_cnt;
  logic              zero_mode;
  logic              pipe_vld;
  logic              pipe_zero;
  logic              pipe_last;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;
  logic [DATA_W:0]   fifo_wdata;
  logic              pop;
  logic              credit_ok;
  logic              issue;
  logic              last_tag;
  logic              p_wrap;
  logic [ADDR_W-1:0] addr;

  assign pop       = !fifo_empty && i_psum_ready;
  assign credit_ok = !(fifo_full && !pop) &&
                     ((int'(fifo_count) + int'(pipe_vld) - int'(pop)) < FIFO_DEPTH);
  assign issue     = (state == ST_LOAD) && credit_ok;
  assign p_wrap    = (cnt_p == i_layer_p - 3'd1);
  assign last_tag  = p_wrap && (cnt_e == i_layer_EF - 7'd1);
  assign addr      = ADDR_W'(psum_addr(cnt_p, cnt_e, iter_cnt, i_layer_EF));

  assign o_psum_glb_re = issue && !zero_mode;
  assign o_psum_glb_ra = o_psum_glb_re ? addr : '0;
  assign fifo_wdata    = {pipe_last, pipe_zero ? {DATA_W{1'b0}} : i_psum_glb_rd};
  assign o_psum_valid  = !fifo_empty;
  assign o_psum_data   = o_psum_valid ? fifo_rdata[DATA_W-1:0] : '0;
  assign o_psum_last   = o_psum_valid && fifo_rdata[DATA_W];
  assign o_iter_done   = (state == ST_UPDATE_BASE);
  assign o_load_done   = (state == ST_DONE);

  psum_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (pipe_vld),
    .i_data  (fifo_wdata),
    .i_pop   (pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Next-state selection for the load sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (i_start) state_nxt = ST_LOAD;
      ST_LOAD:         if (issue && last_tag) state_nxt = ST_DRAIN;
      ST_DRAIN:        if (fifo_empty && !pipe_vld) state_nxt = ST_UPDATE_BASE;
      ST_UPDATE_BASE:  state_nxt = (iter_cnt == i_layer_EF - 7'd1) ? ST_UPDATE_BATCH : ST_IDLE;
      ST_UPDATE_BATCH: state_nxt = (batch_cnt == i_layer_n - 3'd1) ? ST_DONE : ST_IDLE;
      ST_DONE:         state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // State, address walk, pass counters and the one-deep return tag pipe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt_p     <= '0;
      cnt_e     <= '0;
      iter_cnt  <= '0;
      batch_cnt <= '0;
      zero_mode <= 1'b0;
      pipe_vld  <= 1'b0;
      pipe_zero <= 1'b0;
      pipe_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      pipe_vld  <= issue;
      pipe_zero <= zero_mode;
      pipe_last <= last_tag;
      if (state == ST_IDLE && i_start) begin
        zero_mode <= i_zero_init;
        cnt_p     <= '0;
        cnt_e     <= '0;
      end
      if (issue) begin
        if (p_wrap) begin
          cnt_p <= '0;
          cnt_e <= last_tag ? 7'd0 : cnt_e + 7'd1;
        end else begin
          cnt_p <= cnt_p + 3'd1;
        end
      end
      if (state == ST_UPDATE_BASE)
        iter_cnt <= (iter_cnt == i_layer_EF - 7'd1) ? 7'd0 : iter_cnt + 7'd1;
      if (state == ST_UPDATE_BATCH)
        batch_cnt <= (batch_cnt == i_layer_n - 3'd1) ? 3'd0 : batch_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_psum_load_ctrl.sv
// Directed bench for psum_load_ctrl: a 1-cycle-latency GLB model, a
// negedge monitor that logs reads and accepted words, and per-iteration
// comparison against hand-derived address/data/last sequences.
module tb_psum_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        zero_init;
  logic [6:0]  ef;
  logic [2:0]  p;
  logic [2:0]  n;
  logic        re;
  logic [15:0] ra;
  logic [15:0] rd_data = 16'h0;
  logic        valid;
  logic [15:0] data;
  logic        last;
  logic        ready;
  logic        iter_done;
  logic        load_done;

  int total = 0;
  int bad = 0;
  int iter_pulses = 0;
  int load_pulses = 0;
  logic [15:0] rd_q[$];
  logic [16:0] acc_q[$];

  psum_load_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_zero_init   (zero_init),
    .i_layer_EF    (ef),
    .i_layer_p     (p),
    .i_layer_n     (n),
    .o_psum_glb_re (re),
    .o_psum_glb_ra (ra),
    .i_psum_glb_rd (rd_data),
    .o_psum_valid  (valid),
    .o_psum_data   (data),
    .o_psum_last   (last),
    .i_psum_ready  (ready),
    .o_iter_done   (iter_done),
    .o_load_done   (load_done)
  );

  always #5 clk = ~clk;

  // Content stored at each GLB psum address.
  function automatic logic [15:0] glb_word(input logic [15:0] a);
    return a + 16'h1230;
  endfunction

  // GLB model: data valid exactly one cycle after the read enable.
  always @(posedge clk) rd_data <= re ? glb_word(ra) : 16'hDEAD;

  // Monitor: log issued reads, accepted words and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (re) rd_q.push_back(ra);
      if (valid && ready) acc_q.push_back({last, data});
      if (iter_done) iter_pulses++;
      if (load_done) load_pulses++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Start one iteration and wait (bounded) for its completion pulse.
  task automatic applyStimulus(input logic [6:0] ef_v, input logic [2:0] p_v,
                               input logic [2:0] n_v, input logic z);
    logic seen;
    @(posedge clk) #1;
    ef = ef_v; p = p_v; n = n_v; zero_init = z; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; zero_init = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (iter_done) seen = 1'b1;
    end
    if (!seen) checkOutput("iter_done_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
  endtask

  // Compare logged reads/words of one iteration with the expected walk.
  task automatic checkIter(input int ef_v, input int p_v, input int it,
                           input logic z, input int exp_load);
    int nw;
    int k;
    logic [15:0] a;
    logic        l;
    nw = ef_v * p_v;
    checkOutput($sformatf("rd_count it%0d", it), rd_q.size(), z ? 0 : nw);
    checkOutput($sformatf("word_count it%0d", it), acc_q.size(), nw);
    checkOutput($sformatf("iter_done_pulses it%0d", it), iter_pulses, 1);
    checkOutput($sformatf("load_done_pulses it%0d", it), load_pulses, exp_load);
    k = 0;
    for (int e = 0; e < ef_v; e++) begin
      for (int pp = 0; pp < p_v; pp++) begin
        a = 16'(pp * ef_v * ef_v + e * ef_v + it);
        l = (e == ef_v - 1) && (pp == p_v - 1);
        if (!z && k < rd_q.size())
          checkOutput($sformatf("rd_addr it%0d w%0d", it, k), rd_q[k], a);
        if (k < acc_q.size())
          checkOutput($sformatf("word it%0d w%0d", it, k), acc_q[k], {l, z ? 16'h0 : glb_word(a)});
        k++;
      end
    end
    rd_q.delete();
    acc_q.delete();
    iter_pulses = 0;
    load_pulses = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; zero_init = 1'b0;
    ef = 7'd1; p = 3'd1; n = 3'd1; ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_re", re, 0);
    checkOutput("rst_ra", ra, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_last", last, 0);
    checkOutput("rst_iter_done", iter_done, 0);
    checkOutput("rst_load_done", load_done, 0);
    @(posedge clk) #1 rst = 1'b0;

    $display("[TB] basic walk EF=2 p=2 n=1");
    applyStimulus(2, 2, 1, 0);
    checkIter(2, 2, 0, 0, 0);
    applyStimulus(2, 2, 1, 0);
    checkIter(2, 2, 1, 0, 1);

    $display("[TB] backpressure EF=3 p=3 n=1");
    fork
      applyStimulus(3, 3, 1, 0);
      begin
        repeat (3) @(posedge clk);
        #1 ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_re_stalled", re, 0);
        checkOutput("bp_valid_held", valid, 1);
        checkOutput("bp_data_held", data, glb_word(16'd0));
        checkOutput("bp_last_held", last, 0);
        @(posedge clk) #1 ready = 1'b1;
      end
    join
    checkIter(3, 3, 0, 0, 0);
    applyStimulus(3, 3, 1, 0);
    checkIter(3, 3, 1, 0, 0);
    applyStimulus(3, 3, 1, 0);
    checkIter(3, 3, 2, 0, 1);

    $display("[TB] zero init EF=3 p=2 n=1");
    for (int it = 0; it < 3; it++) begin
      applyStimulus(3, 2, 1, 1);
      checkIter(3, 2, it, 1, (it == 2) ? 1 : 0);
    end

    $display("[TB] single word EF=1 p=1 n=2");
    applyStimulus(1, 1, 2, 0);
    checkIter(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 0);
    checkIter(1, 1, 0, 0, 1);

    $display("[TB] start pulses during LOAD and DRAIN");
    fork
      applyStimulus(2, 2, 1, 0);
      begin
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
      end
    join
    checkIter(2, 2, 0, 0, 0);
    applyStimulus(2, 2, 1, 0);
    checkIter(2, 2, 1, 0, 1);

    $display("[TB] reset mid-operation");
    @(posedge clk) #1;
    ef = 7'd2; p = 3'd2; n = 3'd1; start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", valid, 0);
    checkOutput("mid_rst_re", re, 0);
    rd_q.delete();
    acc_q.delete();
    iter_pulses = 0;
    load_pulses = 0;
    repeat (5) @(posedge clk);
    checkOutput("mid_rst_no_words", acc_q.size(), 0);
    checkOutput("mid_rst_no_reads", rd_q.size(), 0);
    checkOutput("mid_rst_no_iter_done", iter_pulses, 0);
    applyStimulus(2, 2, 1, 0);
    checkIter(2, 2, 0, 0, 0);
    applyStimulus(2, 2, 1, 0);
    checkIter(2, 2, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
